// File: rtl/sprite_dma_sched.sv
// Shared glyph ROM scheduler for NSPR font-sprite engines.
// Pulses start per frame and grants one fixed ROM slot per sprite per line.
module sprite_dma_sched #(
    parameter int NSPR  = 4,
    parameter int ADDRW = 9,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame,
    input  logic                  line,
    input  logic [NSPR-1:0]       spr_en,
    input  logic [NSPR*ADDRW-1:0] spr_base,
    input  logic [NSPR*ADDRW-1:0] spr_pos,
    input  logic [NSPR-1:0]       spr_done,
    input  logic [WIDTH-1:0]      rom_data,
    output logic [NSPR-1:0]       start,
    output logic [NSPR-1:0]       dma_avail,
    output logic [ADDRW-1:0]      rom_addr,
    output logic [WIDTH-1:0]      spr_data,
    output logic                  busy,
    output logic                  all_done,
    output logic                  overrun
);

    localparam int SW = (NSPR > 1) ? $clog2(NSPR) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LINE,
        GRANT,
        FLUSH
    } state_t;

    state_t          state, state_d;
    logic [SW-1:0]   slot, slot_d;
    logic [NSPR-1:0] en_q, en_d;
    logic [NSPR-1:0] start_d, avail_d;
    logic [ADDRW-1:0] addr_d;
    logic            busy_d, ovr_d;

    always_comb begin
        state_d = state;
        slot_d  = slot;
        en_d    = en_q;
        ovr_d   = 1'b0;
        if (frame) begin
            // frame beats everything, including a line in the same cycle
            en_d    = spr_en;
            state_d = START;
            slot_d  = '0;
        end else begin
            unique case (state)
                IDLE: state_d = IDLE;
                START: state_d = WAIT_LINE;
                WAIT_LINE: begin
                    if (line) begin
                        state_d = GRANT;
                        slot_d  = '0;
                    end
                end
                GRANT: begin
                    ovr_d = line;
                    if (slot == SW'(NSPR - 1)) begin
                        state_d = FLUSH;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot + 1'b1;
                    end
                end
                FLUSH: begin
                    ovr_d   = line;
                    state_d = WAIT_LINE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Grant outputs are looked ahead from the next slot so slot k lands on t+1+k.
    always_comb begin
        start_d = (state == START) ? en_q : '0;
        avail_d = '0;
        addr_d  = '0;
        if (state_d == GRANT && en_q[slot_d]) begin
            avail_d = NSPR'(1) << slot_d;
            addr_d  = spr_base[slot_d*ADDRW +: ADDRW]
                    + spr_pos[slot_d*ADDRW +: ADDRW];
        end
        busy_d = (state_d == GRANT) || (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot      <= '0;
            en_q      <= '0;
            start     <= '0;
            dma_avail <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            slot      <= slot_d;
            en_q      <= en_d;
            start     <= start_d;
            dma_avail <= avail_d;
            rom_addr  <= addr_d;
            busy      <= busy_d;
            overrun   <= ovr_d;
        end
    end

    assign spr_data = rom_data;
    assign all_done = &(spr_done | ~en_q);

endmodule

// File: tb/tb_sprite_dma_sched.sv
// Directed bench for sprite_dma_sched with a behavioural synchronous ROM.
module tb_sprite_dma_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame = 1'b0;
    logic        line = 1'b0;
    logic [3:0]  spr_en = '0;
    logic [35:0] spr_base = '0;
    logic [35:0] spr_pos = '0;
    logic [3:0]  spr_done = '0;
    logic [7:0]  rom_data;
    logic [3:0]  start;
    logic [3:0]  dma_avail;
    logic [8:0]  rom_addr;
    logic [7:0]  spr_data;
    logic        busy;
    logic        all_done;
    logic        overrun;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sprite_dma_sched #(.NSPR(4), .ADDRW(9), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame(frame), .line(line),
        .spr_en(spr_en), .spr_base(spr_base), .spr_pos(spr_pos),
        .spr_done(spr_done), .rom_data(rom_data), .start(start),
        .dma_avail(dma_avail), .rom_addr(rom_addr), .spr_data(spr_data),
        .busy(busy), .all_done(all_done), .overrun(overrun)
    );

    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input logic [3:0] en);
        frame = 1'b1;
        spr_en = en;
        tick();
        frame = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [8:0] ea [4];
        logic [3:0] ed [4];

        #3;
        check("rst start", start, 0);
        check("rst avail", dma_avail, 0);
        check("rst addr", rom_addr, 0);
        check("rst busy", busy, 0);
        check("rst ovr", overrun, 0);
        check("rst all_done", all_done, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // start pulse two cycles after frame
        frame = 1'b1;
        spr_en = 4'b1011;
        tick();
        frame = 1'b0;
        check("start t+1", start, 0);
        tick();
        check("start t+2", start, 4'b1011);
        tick();
        check("start t+3", start, 0);
        check("all_done low", all_done, 0);

        // full window, all enabled
        spr_base = {9'd30, 9'd20, 9'd10, 9'd0};
        spr_pos  = {9'd3, 9'd2, 9'd1, 9'd0};
        do_frame(4'hF);
        ea = '{9'd0, 9'd11, 9'd22, 9'd33};
        line = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            line = 1'b0;
            check($sformatf("full avail%0d", k), dma_avail, 1 << k);
            check($sformatf("full addr%0d", k), rom_addr, ea[k]);
            check($sformatf("full busy%0d", k), busy, 1);
            if (k > 0)
                check($sformatf("full data%0d", k - 1), spr_data, rom_fn(ea[k-1]));
        end
        tick();
        check("flush avail", dma_avail, 0);
        check("flush busy", busy, 1);
        check("full data3", spr_data, rom_fn(ea[3]));
        tick();
        check("busy t+6", busy, 0);
        spr_done = 4'hF;
        #1 check("all_done hi", all_done, 1);
        spr_done = 4'b0111;
        #1 check("all_done lo", all_done, 0);
        spr_done = 4'h0;

        // sparse enable
        spr_base = {9'd30, 9'd20, 9'd10, 9'd5};
        do_frame(4'b0101);
        ea = '{9'd5, 9'd0, 9'd22, 9'd0};
        ed = '{4'd1, 4'd0, 4'd4, 4'd0};
        line = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            line = 1'b0;
            check($sformatf("sparse avail%0d", k), dma_avail, ed[k]);
            check($sformatf("sparse addr%0d", k), rom_addr, ea[k]);
        end
        tick();
        tick();

        // address wrap and overrun
        spr_base = {9'd30, 9'd20, 9'd10, 9'd500};
        spr_pos  = {9'd3, 9'd2, 9'd1, 9'd20};
        line = 1'b1;
        tick();
        line = 1'b0;
        check("wrap avail", dma_avail, 1);
        check("wrap addr", rom_addr, 8);
        tick();
        line = 1'b1;
        check("ovr slot1 avail", dma_avail, 0);
        check("ovr before", overrun, 0);
        tick();
        line = 1'b0;
        check("ovr slot2 avail", dma_avail, 4);
        check("ovr slot2 addr", rom_addr, 22);
        check("ovr pulse", overrun, 1);
        tick();
        check("ovr clear", overrun, 0);
        check("ovr slot3 avail", dma_avail, 0);
        tick();
        check("ovr flush busy", busy, 1);
        tick();
        check("ovr idle busy", busy, 0);

        // frame kills an open window
        spr_base = {9'd30, 9'd20, 9'd10, 9'd0};
        spr_pos  = {9'd3, 9'd2, 9'd1, 9'd0};
        do_frame(4'hF);
        line = 1'b1;
        tick();
        line = 1'b0;
        check("abort slot0", dma_avail, 1);
        tick();
        check("abort slot1", dma_avail, 2);
        frame = 1'b1;
        spr_en = 4'b0110;
        tick();
        frame = 1'b0;
        check("abort avail", dma_avail, 0);
        check("abort busy", busy, 0);
        tick();
        check("abort start", start, 4'b0110);
        check("abort avail2", dma_avail, 0);
        line = 1'b1;
        tick();
        line = 1'b0;
        check("relaunch slot0", dma_avail, 0);
        check("relaunch busy", busy, 1);
        tick();
        check("relaunch slot1", dma_avail, 2);

        // async reset mid-grant
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst avail", dma_avail, 0);
        check("arst addr", rom_addr, 0);
        check("arst busy", busy, 0);
        check("arst all_done", all_done, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // simultaneous frame and line
        frame = 1'b1;
        line = 1'b1;
        spr_en = 4'hF;
        tick();
        frame = 1'b0;
        line = 1'b0;
        check("fl avail", dma_avail, 0);
        check("fl ovr", overrun, 0);
        tick();
        check("fl start", start, 4'hF);
        check("fl ovr2", overrun, 0);
        check("fl busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
